// File: rtl/pixel_write_arbiter_pkg.sv
// Shared definitions for the pixel write arbiter: colour format, arbiter
// state encoding and a width helper.
package pixel_write_arbiter_pkg;

    // RGB565 pixel colour
    localparam int unsigned COLOR_WIDTH = 16;

    localparam logic [COLOR_WIDTH-1:0] COLOR_NONE  = 16'h0000;
    localparam logic [COLOR_WIDTH-1:0] COLOR_WHITE = 16'hFFFF;
    localparam logic [COLOR_WIDTH-1:0] COLOR_RED   = 16'hF800;
    localparam logic [COLOR_WIDTH-1:0] COLOR_GREEN = 16'h07E0;
    localparam logic [COLOR_WIDTH-1:0] COLOR_BLUE  = 16'h001F;

    // Arbiter state encoding
    typedef logic [0:0] arb_state_t;
    localparam arb_state_t ARB_IDLE_RR = 1'b0;
    localparam arb_state_t ARB_LOCKED  = 1'b1;

    // Index width that never collapses to zero bits
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pixel_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr.
// Ports: valid (request vector), ptr (search start), grant (one-hot or zero),
//        idx (index of grant), any_valid (at least one request).
module rr_pick
    import pixel_write_arbiter_pkg::*;
#(
    parameter int unsigned N = 3
) (
    input  logic [N-1:0]               valid,
    input  logic [clog2_min1(N)-1:0]   ptr,
    output logic [N-1:0]               grant,
    output logic [clog2_min1(N)-1:0]   idx,
    output logic                       any_valid
);

    localparam int unsigned IW = clog2_min1(N);

    logic [IW-1:0] cand;

    // Rotating first-one search starting at ptr
    always_comb begin
        grant     = '0;
        idx       = '0;
        any_valid = 1'b0;
        cand      = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = IW'((32'(ptr) + k) % N);
            if (!any_valid && valid[cand]) begin
                any_valid   = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/pixel_write_arbiter.sv
// Round-robin arbiter sharing one frame-buffer pixel write port between
// NUM_REQ producers, with per-requester lock for atomic pixel sequences and
// a watchdog that releases a lock whose owner goes idle.
// Ports: clk, reset (sync, active-high);
//        req_valid/req_lock/req_x/req_y/req_color: packed per-requester offers;
//        req_ready: one-hot-or-zero grant (combinational);
//        wr_en/wr_x/wr_y/wr_color: registered frame-buffer write;
//        locked: registered LOCKED flag; owner: last accepted requester.
module pixel_write_arbiter
    import pixel_write_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 3,
    parameter int unsigned WIDTH        = 640,
    parameter int unsigned HEIGHT       = 480,
    parameter int unsigned LOCK_TIMEOUT = 16
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_REQ-1:0]                    req_valid,
    input  logic [NUM_REQ-1:0]                    req_lock,
    input  logic [NUM_REQ*$clog2(WIDTH)-1:0]      req_x,
    input  logic [NUM_REQ*$clog2(HEIGHT)-1:0]     req_y,
    input  logic [NUM_REQ*COLOR_WIDTH-1:0]        req_color,
    output logic [NUM_REQ-1:0]                    req_ready,
    output logic                                  wr_en,
    output logic [$clog2(WIDTH)-1:0]              wr_x,
    output logic [$clog2(HEIGHT)-1:0]             wr_y,
    output logic [COLOR_WIDTH-1:0]                wr_color,
    output logic                                  locked,
    output logic [clog2_min1(NUM_REQ)-1:0]        owner
);

    localparam int unsigned XW = $clog2(WIDTH);
    localparam int unsigned YW = $clog2(HEIGHT);
    localparam int unsigned IW = clog2_min1(NUM_REQ);
    localparam int unsigned CW = clog2_min1(LOCK_TIMEOUT + 1);

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        return (i == IW'(NUM_REQ - 1)) ? '0 : i + IW'(1);
    endfunction

    arb_state_t       state_q, state_d;
    logic [IW-1:0]    rr_ptr, rr_ptr_d;
    logic [IW-1:0]    owner_d;
    logic [CW-1:0]    cnt, cnt_d;

    logic [NUM_REQ-1:0] rr_grant;
    logic [IW-1:0]      rr_idx;
    logic               rr_any;

    logic               xfer;
    logic [IW-1:0]      xfer_idx;
    logic [XW-1:0]      sel_x;
    logic [YW-1:0]      sel_y;
    logic [COLOR_WIDTH-1:0] sel_color;
    logic               in_range;

    rr_pick #(.N(NUM_REQ)) u_rr_pick (
        .valid     (req_valid),
        .ptr       (rr_ptr),
        .grant     (rr_grant),
        .idx       (rr_idx),
        .any_valid (rr_any)
    );

    // Next-state, grant and transfer decode
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr;
        owner_d   = owner;
        cnt_d     = cnt;
        req_ready = '0;
        xfer      = 1'b0;
        xfer_idx  = owner;
        case (state_q)
            ARB_IDLE_RR: begin
                if (rr_any) begin
                    req_ready = rr_grant;
                    xfer      = 1'b1;
                    xfer_idx  = rr_idx;
                    owner_d   = rr_idx;
                    rr_ptr_d  = next_idx(rr_idx);
                    if (req_lock[rr_idx]) begin
                        state_d = ARB_LOCKED;
                        cnt_d   = '0;
                    end
                end
            end
            ARB_LOCKED: begin
                // Only the owner may be granted, even while it is idle
                req_ready[owner] = req_valid[owner];
                if (req_valid[owner]) begin
                    xfer     = 1'b1;
                    xfer_idx = owner;
                    if (req_lock[owner]) begin
                        cnt_d = '0;
                    end else begin
                        state_d  = ARB_IDLE_RR;
                        rr_ptr_d = next_idx(owner);
                    end
                end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
                    // Watchdog: the LOCK_TIMEOUT-th idle cycle releases the lock
                    state_d  = ARB_IDLE_RR;
                    rr_ptr_d = next_idx(owner);
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            default: begin
                state_d = ARB_IDLE_RR;
            end
        endcase
    end

    // Payload mux for the accepted requester
    always_comb begin
        sel_x     = '0;
        sel_y     = '0;
        sel_color = COLOR_NONE;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (xfer_idx == IW'(i)) begin
                sel_x     = req_x[i*XW +: XW];
                sel_y     = req_y[i*YW +: YW];
                sel_color = req_color[i*COLOR_WIDTH +: COLOR_WIDTH];
            end
        end
        in_range = ({1'b0, sel_x} < (XW+1)'(WIDTH)) && ({1'b0, sel_y} < (YW+1)'(HEIGHT));
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ARB_IDLE_RR;
            rr_ptr   <= '0;
            owner    <= '0;
            cnt      <= '0;
            wr_en    <= 1'b0;
            wr_x     <= '0;
            wr_y     <= '0;
            wr_color <= COLOR_NONE;
            locked   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr   <= rr_ptr_d;
            owner    <= owner_d;
            cnt      <= cnt_d;
            // Out-of-range pixels are consumed but never strobed
            wr_en    <= xfer && in_range;
            if (xfer) begin
                wr_x     <= sel_x;
                wr_y     <= sel_y;
                wr_color <= sel_color;
            end
            locked   <= (state_d == ARB_LOCKED);
        end
    end

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Scoreboard bench for pixel_write_arbiter: directed scenarios plus random
// traffic, checked against a rule-level model of the arbitration.
module tb_pixel_write_arbiter;
    import pixel_write_arbiter_pkg::*;

    localparam int NUM_REQ      = 3;
    localparam int WIDTH        = 640;
    localparam int HEIGHT       = 480;
    localparam int LOCK_TIMEOUT = 16;
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int IW = clog2_min1(NUM_REQ);

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_lock;
    logic [NUM_REQ*XW-1:0]          req_x;
    logic [NUM_REQ*YW-1:0]          req_y;
    logic [NUM_REQ*COLOR_WIDTH-1:0] req_color;
    logic [NUM_REQ-1:0]             req_ready;
    logic                           wr_en;
    logic [XW-1:0]                  wr_x;
    logic [YW-1:0]                  wr_y;
    logic [COLOR_WIDTH-1:0]         wr_color;
    logic                           locked;
    logic [IW-1:0]                  owner;

    pixel_write_arbiter #(
        .NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .LOCK_TIMEOUT(LOCK_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_lock(req_lock),
        .req_x(req_x), .req_y(req_y), .req_color(req_color),
        .req_ready(req_ready),
        .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color),
        .locked(locked), .owner(owner)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model state: arbitration rules expressed directly
    typedef struct { int stamp; int x; int y; int c; } exp_t;
    exp_t q[$];
    bit   m_locked;
    int   m_owner, m_ptr, m_idle;
    int   m_wx, m_wy, m_wc;
    bit [NUM_REQ-1:0] pend;

    function automatic int exp_grant();
        if (m_locked) return req_valid[m_owner] ? m_owner : -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            int i;
            i = (m_ptr + k) % NUM_REQ;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_owner = 0; m_ptr = 0; m_idle = 0;
        m_wx = 0; m_wy = 0; m_wc = int'(COLOR_NONE);
        pend = '0;
        q.delete();
    endtask

    task automatic model_step();
        int g, x, y, c;
        logic [NUM_REQ-1:0] er;
        chk("locked", locked, m_locked);
        chk("owner", owner, m_owner);
        chk("wr_x", wr_x, m_wx);
        chk("wr_y", wr_y, m_wy);
        chk("wr_color", wr_color, m_wc);
        g = exp_grant();
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        chk("req_ready", req_ready, er);
        pend = req_valid & ~er;
        if (g >= 0) begin
            x = int'(req_x[g*XW +: XW]);
            y = int'(req_y[g*YW +: YW]);
            c = int'(req_color[g*COLOR_WIDTH +: COLOR_WIDTH]);
            m_wx = x; m_wy = y; m_wc = c;
            if (x < WIDTH && y < HEIGHT) q.push_back('{cyc, x, y, c});
            m_owner = g;
            if (!m_locked) begin
                m_ptr    = (g + 1) % NUM_REQ;
                m_locked = req_lock[g];
                m_idle   = 0;
            end else if (!req_lock[g]) begin
                m_locked = 0;
                m_ptr    = (g + 1) % NUM_REQ;
            end else begin
                m_idle = 0;
            end
        end else if (m_locked) begin
            m_idle++;
            if (m_idle >= LOCK_TIMEOUT) begin
                m_locked = 0;
                m_idle   = 0;
                m_ptr    = (m_owner + 1) % NUM_REQ;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            #1;
            if (reset) model_reset();
            else model_step();
        end
    end

    // Monitor: every strobed write must match the oldest expected write
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (q.size() == 0) begin
                chk("spurious_write", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("write_latency", cyc - 1, e.stamp);
                chk("write_x", wr_x, e.x);
                chk("write_y", wr_y, e.y);
                chk("write_color", wr_color, e.c);
            end
        end
    end

    // Requesters must hold payload and lock while stalled
    logic [NUM_REQ-1:0]             h_pend, h_lock;
    logic [NUM_REQ*XW-1:0]          h_x;
    logic [NUM_REQ*YW-1:0]          h_y;
    logic [NUM_REQ*COLOR_WIDTH-1:0] h_c;
    initial h_pend = '0;
    always @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (h_pend[i] && !reset)
                assert (req_lock[i] == h_lock[i] && req_x[i*XW +: XW] == h_x[i*XW +: XW] &&
                        req_y[i*YW +: YW] == h_y[i*YW +: YW] &&
                        req_color[i*COLOR_WIDTH +: COLOR_WIDTH] == h_c[i*COLOR_WIDTH +: COLOR_WIDTH])
                else $error("requester %0d changed payload while stalled", i);
        end
        h_pend <= req_valid & ~req_ready & {NUM_REQ{~reset}};
        h_lock <= req_lock;
        h_x    <= req_x;
        h_y    <= req_y;
        h_c    <= req_color;
    end

    task automatic set_req(input int i, input bit v, input bit l, input int x, input int y, input int c);
        req_valid[i] = v;
        req_lock[i]  = l;
        req_x[i*XW +: XW] = XW'(x);
        req_y[i*YW +: YW] = YW'(y);
        req_color[i*COLOR_WIDTH +: COLOR_WIDTH] = COLOR_WIDTH'(c);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One cycle of traffic; stalled requesters keep their offer
    task automatic rand_cycle(input int vprob, input int lprob, input bit [NUM_REQ-1:0] mask);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pend[i]) begin
                if (mask[i] && $urandom_range(0, 99) < vprob)
                    set_req(i, 1'b1, $urandom_range(0, 99) < lprob, int'($urandom_range(0, 700)),
                            int'($urandom_range(0, 500)), int'($urandom_range(0, 65535)));
                else
                    req_valid[i] = 1'b0;
            end
        end
        step();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) rand_cycle(0, 0, '0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        req_valid = '0; req_lock = '0; req_x = '0; req_y = '0; req_color = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #2;
        chk("reset_wr_en", wr_en, 0);
        chk("reset_locked", locked, 0);
        chk("reset_owner", owner, 0);
        chk("reset_wr_color", wr_color, COLOR_NONE);

        // Single requester streaming a row
        for (int k = 0; k < 4; k++) begin
            set_req(0, 1'b1, 1'b0, k, 0, COLOR_BLUE);
            step();
        end
        idle(4);

        // Two requesters continuously valid alternate
        for (int k = 0; k < 8; k++) rand_cycle(100, 0, 3'b011);
        idle(80);

        // Locked plus-sign excludes the other requester
        set_req(1, 1'b1, 1'b1, 5, 5, COLOR_WHITE);
        step();
        set_req(0, 1'b1, 1'b0, 50, 50, COLOR_BLUE);
        set_req(1, 1'b1, 1'b1, 6, 5, COLOR_WHITE);
        #1 chk("lock_exclusive", req_ready, 3'b010);
        step();
        set_req(1, 1'b1, 1'b1, 5, 6, COLOR_WHITE); step();
        set_req(1, 1'b1, 1'b1, 4, 5, COLOR_WHITE); step();
        set_req(1, 1'b1, 1'b0, 5, 4, COLOR_WHITE);
        #1 chk("lock_burst_locked", locked, 1);
        step();
        set_req(1, 1'b0, 1'b0, 5, 4, COLOR_WHITE);
        #1 chk("after_burst_grant", req_ready, 3'b001);
        step();
        idle(80);

        // Stalled lock owner released by the watchdog
        set_req(2, 1'b1, 1'b1, 1, 1, COLOR_WHITE);
        step();
        set_req(2, 1'b0, 1'b0, 1, 1, COLOR_WHITE);
        set_req(0, 1'b1, 1'b0, 10, 10, COLOR_RED);
        set_req(1, 1'b1, 1'b0, 11, 11, COLOR_RED);
        #1;
        n = 0;
        while (req_ready[0] !== 1'b1 && n < 40) begin
            n++;
            @(posedge clk);
            #2;
        end
        chk("timeout_wait", n, LOCK_TIMEOUT);
        chk("timeout_grant", req_ready, 3'b001);
        step();
        idle(80);

        // Out-of-range pixel consumed without a strobe
        set_req(0, 1'b1, 1'b0, 640, 10, COLOR_BLUE); step();
        set_req(0, 1'b1, 1'b0, 639, 479, COLOR_GREEN);
        chk("oor_wr_en", wr_en, 0);
        chk("oor_wr_x", wr_x, 640);
        step();
        set_req(0, 1'b0, 1'b0, 639, 479, COLOR_GREEN);
        chk("edge_wr_en", wr_en, 1);
        chk("edge_wr_xy", {wr_x, wr_y}, {10'd639, 9'd479});
        idle(80);

        // Reset in the middle of a locked burst
        set_req(1, 1'b1, 1'b1, 20, 20, COLOR_RED); step();
        set_req(1, 1'b1, 1'b1, 21, 20, COLOR_RED);
        set_req(0, 1'b1, 1'b0, 30, 30, COLOR_BLUE);
        step();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        #1;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_locked", locked, 0);
        chk("rst_owner", owner, 0);
        chk("rst_first_grant", req_ready, 3'b001);
        step();
        idle(80);

        // Random traffic at several loads
        for (int k = 0; k < 1500; k++) rand_cycle(70, 40, '1);
        for (int k = 0; k < 1500; k++) rand_cycle(30, 50, '1);
        for (int k = 0; k < 1500; k++) rand_cycle(8, 60, '1);
        idle(100);
        chk("queue_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_write_arbiter.md
Name: pixel_write_arbiter

Overview:
Shares the single frame-buffer pixel write port between NUM_REQ pixel producers, such as the brush/line drawer, the cursor renderer and the clear-screen engine. Arbitration is round-robin with a valid/ready handshake per requester. A per-requester lock keeps the port for multi-pixel atomic sequences, for example a 5-pixel cursor plus-sign. A lock watchdog stops a stalled owner from starving the other requesters. Output drives the frame-buffer write port directly, registered.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
WIDTH, 640, frame width in pixels; XW = $clog2(WIDTH)
HEIGHT, 480, frame height in pixels; YW = $clog2(HEIGHT)
LOCK_TIMEOUT, 16, idle cycles of a lock owner before the lock is forcibly released (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
req_valid  in  NUM_REQ  requester i offers a pixel
req_lock  in  NUM_REQ  requester i wants the port kept after this pixel
req_x  in  NUM_REQ*XW  packed x coordinate; requester i in slice [i*XW +: XW]
req_y  in  NUM_REQ*YW  packed y coordinate, same slicing
req_color  in  NUM_REQ*COLOR_WIDTH  packed pixel colour
req_ready  out  NUM_REQ  one-hot-or-zero grant; combinational from state and req_valid
wr_en  out  1  frame-buffer write strobe (registered)
wr_x  out  XW  write x (registered)
wr_y  out  YW  write y (registered)
wr_color  out  COLOR_WIDTH  write colour (registered)
locked  out  1  arbiter is in LOCKED (registered)
owner  out  $clog2(NUM_REQ)  index of last accepted requester (registered)

Behaviour:
- Clock/reset: clock clk; reset is synchronous and active-high. Reset values: wr_en=0, wr_x=0, wr_y=0, wr_color=COLOR_NONE, locked=0, owner=0, rr_ptr=0, timeout counter=0, state ARB.
- Transfer: requester i transfers in a cycle where req_valid[i] && req_ready[i]. At most one transfer per cycle.
- Write latency: the accepted pixel appears on wr_x/wr_y/wr_color with wr_en=1 on the next cycle. wr_en=0 in any cycle following no transfer.
- Out-of-range pixels (x>=WIDTH or y>=HEIGHT) are accepted and consumed, but wr_en stays 0 for them. wr_x/y/color still update.
- State ARB:
  - req_ready goes to the first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - On a transfer by i: rr_ptr<=(i+1) mod NUM_REQ and owner<=i.
  - If req_lock[i]=1 on that transfer, go to LOCKED and clear the timeout counter.
  - With no valid requester, req_ready=0 and nothing changes.
- State LOCKED:
  - Only req_ready[owner]=req_valid[owner]; all other ready bits are 0, even when the owner is idle.
  - Owner transfer with req_lock=1: stay in LOCKED and clear the counter.
  - Owner transfer with req_lock=0: this is the final pixel; go to ARB with rr_ptr<=owner+1.
  - No owner transfer: increment the counter. When it reaches LOCK_TIMEOUT, go to ARB the following cycle with rr_ptr<=owner+1; no transfer occurs in the timeout cycle.
- A timed-out owner re-enters ordinary round-robin and may re-lock on its next grant.
- locked mirrors the LOCKED state as registered.
- req_ready never depends on req_lock, so there is no combinational loop through lock.
- Reset mid-lock: immediate return to ARB with the reset values above; a pending wr_en is dropped.
- Requesters must hold x/y/color/lock stable while valid && !ready. This is an assertion in the bench, not enforced by the RTL.

Decomposition:
- Shared package (common.sv): COLOR_WIDTH, COLOR_NONE and the colour constants already there.
- Shared package additions: arb_state_t enum {ARB_IDLE_RR, ARB_LOCKED}; function clog2_min1.
- Sub-module rr_pick #(N): combinational; inputs valid vector and pointer; outputs one-hot grant and index plus any_valid.

Test Plan:
1. Only req0 valid for 4 cycles with (x,y)=(0,0),(1,0),(2,0),(3,0), BLUE, lock=0 -> req_ready[0]=1 every cycle; wr_en=1 on cycles 2..5 with the same coordinates; owner=0.
2. req0 and req1 both continuously valid, no lock, after reset -> grants alternate 0,1,0,1; wr_x shows req0/req1 values interleaved one cycle later.
3. req1 sends 5 pixels of a plus-sign at (5,5),(6,5),(5,6),(4,5),(5,4) with lock=1,1,1,1,0 while req0 valid throughout -> req_ready[0]=0 for all 5 cycles and locked=1 during the burst; req0 granted on cycle 6.
4. req2 locks, then drops valid with req0 valid, LOCK_TIMEOUT=16 -> req_ready[0]=0 for 16 cycles, locked falls, req0 granted on the next cycle; rr_ptr=0 so req0 beats req1.
5. req0 sends (640,10) then (639,479) -> both accepted; wr_en=0 for the first, wr_en=1 with (639,479) for the second.
6. reset asserted during a locked burst of req1 -> next cycle: wr_en=0, locked=0, owner=0; req0 granted first after reset release.
